// File: rtl/vga_src_sched_if.sv
// vga_src_sched_if
//   Bundles the pixel-stage signals of the display-source scheduler.
//   master : timing generator / colour-bar / FIFO side (drives coordinates,
//            requests, bar and FIFO data; observes read strobe and pixels)
//   slave  : the scheduler itself
//   Signals: pix_x/pix_y (12b coords), key_next, auto_en, bar_data (16b),
//            fifo_data (16b), fifo_empty, fifo_rd_en, pix_data (16b),
//            mode (2b), uflow_cnt (16b).
interface vga_src_sched_if;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        key_next;
  logic        auto_en;
  logic [15:0] bar_data;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] pix_data;
  logic [1:0]  mode;
  logic [15:0] uflow_cnt;

  modport master (
    output pix_x, pix_y, key_next, auto_en, bar_data, fifo_data, fifo_empty,
    input  fifo_rd_en, pix_data, mode, uflow_cnt
  );

  modport slave (
    input  pix_x, pix_y, key_next, auto_en, bar_data, fifo_data, fifo_empty,
    output fifo_rd_en, pix_data, mode, uflow_cnt
  );
endinterface

// File: rtl/vga_src_sched.sv
// vga_src_sched
//   Frame-synchronous RGB565 pixel-source scheduler. Picks colour bars, a
//   solid colour, a grid or the SDRAM image stream; mode changes (key pulse
//   or auto timer) take effect only at the last active pixel of a frame.
//   Ports: vga_clk (pixel clock), sys_rst_n (async, active-low),
//          bus (vga_src_sched_if.slave: coordinates, requests, source data,
//          FIFO read strobe, registered pixel, mode, underflow count).
//
//   state   | meaning
//   M_BAR   | external colour-bar data passed through
//   M_SOLID | solid colour from table, next colour every frame
//   M_GRID  | white grid lines on black
//   M_IMG   | pixels read from SDRAM FIFO, underflow shown as UFLOW_COLOR
module vga_src_sched #(
  parameter logic [11:0] H_VALID     = 12'd640,
  parameter logic [11:0] V_VALID     = 12'd480,
  parameter logic [7:0]  AUTO_FRAMES = 8'd120,
  parameter logic [2:0]  GRID_SHIFT  = 3'd5,
  parameter logic [15:0] UFLOW_COLOR = 16'h8410
) (
  input logic            vga_clk,
  input logic            sys_rst_n,
  vga_src_sched_if.slave bus
);

  typedef enum logic [1:0] {M_BAR = 2'd0, M_SOLID = 2'd1, M_GRID = 2'd2, M_IMG = 2'd3} mode_e;

  localparam logic [11:0] GRID_MASK = (12'd1 << GRID_SHIFT) - 12'd1;

  mode_e       mode_q, mode_d;
  logic        key_pend_q, key_pend_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]  solid_idx_q, solid_idx_d;
  logic [15:0] uflow_q;
  logic [15:0] pix_q;

  logic        s1_active, s1_grid, s1_hit, s1_miss;
  mode_e       s1_mode;
  logic [15:0] s1_solid;

  logic        active, frame_end, auto_expire, advance, grid_hit, rd_en;
  logic [15:0] solid_color;

  assign active      = (bus.pix_x < H_VALID) && (bus.pix_y < V_VALID);
  assign frame_end   = active && (bus.pix_x == H_VALID - 12'd1) && (bus.pix_y == V_VALID - 12'd1);
  assign auto_expire = bus.auto_en && (frame_cnt_q == AUTO_FRAMES - 8'd1);
  assign advance     = frame_end && (key_pend_q || auto_expire);
  assign grid_hit    = ((bus.pix_x & GRID_MASK) == 12'd0) || ((bus.pix_y & GRID_MASK) == 12'd0);
  // mode_q resets asynchronously, so the strobe drops with reset and no edge.
  assign rd_en       = (mode_q == M_IMG) && active && !bus.fifo_empty;

  always_comb begin
    solid_color = 16'hF800;
    case (solid_idx_q)
      3'd0: solid_color = 16'hF800;
      3'd1: solid_color = 16'hFC00;
      3'd2: solid_color = 16'hFFE0;
      3'd3: solid_color = 16'h07E0;
      3'd4: solid_color = 16'h07FF;
      3'd5: solid_color = 16'h001F;
      3'd6: solid_color = 16'hF81F;
      3'd7: solid_color = 16'hFFFF;
      default: solid_color = 16'hF800;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    key_pend_d  = key_pend_q | bus.key_next;
    frame_cnt_d = frame_cnt_q;
    solid_idx_d = solid_idx_q;

    if (advance) begin
      case (mode_q)
        M_BAR:   mode_d = M_SOLID;
        M_SOLID: mode_d = M_GRID;
        M_GRID:  mode_d = M_IMG;
        M_IMG:   mode_d = M_BAR;
        default: mode_d = M_BAR;
      endcase
      // A pulse landing exactly on the advancing pixel belongs to the next frame.
      key_pend_d = bus.key_next;
    end

    if (!bus.auto_en || advance)
      frame_cnt_d = 8'd0;
    else if (frame_end)
      frame_cnt_d = frame_cnt_q + 8'd1;

    if (advance && mode_q == M_BAR)
      solid_idx_d = 3'd0;
    else if (frame_end && mode_q == M_SOLID)
      solid_idx_d = solid_idx_q + 3'd1;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q      <= M_BAR;
      key_pend_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
      solid_idx_q <= 3'd0;
    end else begin
      mode_q      <= mode_d;
      key_pend_q  <= key_pend_d;
      frame_cnt_q <= frame_cnt_d;
      solid_idx_q <= solid_idx_d;
    end
  end

  // Stage 1: everything that depends on the current coordinate and mode is
  // captured here, so a mode change at frame_end only affects the next frame.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_active <= 1'b0;
      s1_mode   <= M_BAR;
      s1_grid   <= 1'b0;
      s1_solid  <= 16'h0000;
      s1_hit    <= 1'b0;
      s1_miss   <= 1'b0;
    end else begin
      s1_active <= active;
      s1_mode   <= mode_q;
      s1_grid   <= grid_hit;
      s1_solid  <= solid_color;
      s1_hit    <= rd_en;
      s1_miss   <= (mode_q == M_IMG) && active && bus.fifo_empty;
    end
  end

  // Stage 2: bar_data and fifo_data arrive one cycle after their coordinate.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_q   <= 16'h0000;
      uflow_q <= 16'h0000;
    end else begin
      if (!s1_active) begin
        pix_q <= 16'h0000;
      end else begin
        case (s1_mode)
          M_BAR:   pix_q <= bus.bar_data;
          M_SOLID: pix_q <= s1_solid;
          M_GRID:  pix_q <= s1_grid ? 16'hFFFF : 16'h0000;
          M_IMG:   pix_q <= s1_hit ? bus.fifo_data : UFLOW_COLOR;
          default: pix_q <= 16'h0000;
        endcase
      end
      if (s1_miss && uflow_q != 16'hFFFF)
        uflow_q <= uflow_q + 16'd1;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.pix_data   = pix_q;
  assign bus.mode       = mode_q;
  assign bus.uflow_cnt  = uflow_q;

endmodule
